// File: rtl/pe_result_drain_if.sv
// Stream bundle between the accumulator bank, the result drain and the writeback path.
// The master modport is the drain itself; the slave modport is its surroundings.
interface pe_result_drain_if #(
  parameter int NUM_RESULTS  = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int LANES        = 4
);
  localparam int NUM_BEATS = (NUM_RESULTS + LANES - 1) / LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic                                i_results_valid;
  logic [NUM_RESULTS*RESULT_WIDTH-1:0] i_results;
  logic                                o_results_ready;
  logic                                o_valid;
  logic                                i_ready;
  logic [LANES*RESULT_WIDTH-1:0]       o_data;
  logic [BEAT_W-1:0]                   o_beat;
  logic                                o_last;
  logic                                o_overflow;

  modport master (
    input  i_results_valid, i_results, i_ready,
    output o_results_ready, o_valid, o_data, o_beat, o_last, o_overflow
  );

  modport slave (
    output i_results_valid, i_results, i_ready,
    input  o_results_ready, o_valid, o_data, o_beat, o_last, o_overflow
  );
endinterface

// File: rtl/pe_result_drain.sv
// Captures a full flushed result vector in one cycle and serializes it as
// LANES-wide beats on a valid/ready stream, allowing back-to-back sets.
module pe_result_drain #(
  parameter int NUM_RESULTS  = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int LANES        = 4
) (
  input  logic              clock,
  input  logic              resetn,
  pe_result_drain_if.master bus
);
  localparam int NUM_BEATS = (NUM_RESULTS + LANES - 1) / LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int BEAT_BITS = LANES * RESULT_WIDTH;
  localparam int BUF_BITS  = NUM_RESULTS * RESULT_WIDTH;
  localparam int PAD_BITS  = NUM_BEATS * BEAT_BITS;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic FIRST_IS_LAST = (NUM_BEATS == 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state_reg;
  logic [BEAT_W-1:0]   beat_reg;
  logic                valid_reg;
  logic                last_reg;
  logic                overflow_reg;
  logic [BUF_BITS-1:0] buf_reg;
  logic [PAD_BITS-1:0] padded;
  logic [BEAT_BITS-1:0] beat_words [NUM_BEATS];
  logic                capture;

  // New set is accepted when idle, or exactly as the final beat is handed off.
  assign bus.o_results_ready = (state_reg == IDLE) || (last_reg && bus.i_ready);
  assign capture             = bus.i_results_valid && bus.o_results_ready;

  // Zero-extension supplies the zero lanes of a partial final beat.
  assign padded = PAD_BITS'(buf_reg);

  generate
    for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
      assign beat_words[gi] = padded[gi*BEAT_BITS +: BEAT_BITS];
    end
  endgenerate

  assign bus.o_valid    = valid_reg;
  assign bus.o_beat     = beat_reg;
  assign bus.o_last     = last_reg;
  assign bus.o_overflow = overflow_reg;
  assign bus.o_data     = valid_reg ? beat_words[beat_reg] : '0;

  // Result buffer carries no reset; it is only observed while a beat is valid.
  always_ff @(posedge clock) begin
    if (capture) begin
      buf_reg <= bus.i_results;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (bus.i_results_valid && !bus.o_results_ready) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (capture) begin
            state_reg <= DRAIN;
            beat_reg  <= '0;
            valid_reg <= 1'b1;
            last_reg  <= FIRST_IS_LAST;
          end
        end
        DRAIN: begin
          if (bus.i_ready) begin
            if (last_reg) begin
              beat_reg <= '0;
              if (capture) begin
                last_reg <= FIRST_IS_LAST;
              end else begin
                state_reg <= IDLE;
                valid_reg <= 1'b0;
                last_reg  <= 1'b0;
              end
            end else begin
              beat_reg <= beat_reg + 1'b1;
              last_reg <= ((beat_reg + 1'b1) == LAST_BEAT);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          beat_reg  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pe_result_drain.sv
// Scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_pe_result_drain;
  typedef struct {
    logic [127:0] data;
    logic [1:0]   beat;
    logic         last;
  } exp_t;

  logic clock;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  pe_result_drain_if #(.NUM_RESULTS(16), .RESULT_WIDTH(32), .LANES(4)) bus_a ();
  pe_result_drain_if #(.NUM_RESULTS(6),  .RESULT_WIDTH(32), .LANES(4)) bus_b ();

  pe_result_drain #(.NUM_RESULTS(16), .RESULT_WIDTH(32), .LANES(4)) dut_a (
    .clock(clock), .resetn(resetn), .bus(bus_a));
  pe_result_drain #(.NUM_RESULTS(6), .RESULT_WIDTH(32), .LANES(4)) dut_b (
    .clock(clock), .resetn(resetn), .bus(bus_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Expected beats of one set: word k = base + k, lanes at or past n read as zero.
  task automatic push_set(input int n, input logic [31:0] base, input bit to_b);
    int nb;
    exp_t e;
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < 4; j++) begin
        if (b*4 + j < n) e.data[j*32 +: 32] = base + 32'(b*4 + j);
      end
      e.beat = 2'(b);
      e.last = (b == nb - 1);
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  // Called at posedge+1; holds the strobe for exactly one edge.
  task automatic strobe_a(input logic [31:0] base, input bit expect_capture);
    for (int k = 0; k < 16; k++) bus_a.i_results[k*32 +: 32] = base + 32'(k);
    bus_a.i_results_valid = 1'b1;
    if (expect_capture) push_set(16, base, 1'b0);
    $display("strobe A base=%0h capture_expected=%0d", base, expect_capture);
    @(posedge clock); #1;
    bus_a.i_results_valid = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] base);
    for (int k = 0; k < 6; k++) bus_b.i_results[k*32 +: 32] = base + 32'(k);
    bus_b.i_results_valid = 1'b1;
    push_set(6, base, 1'b1);
    $display("strobe B base=%0h", base);
    @(posedge clock); #1;
    bus_b.i_results_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input bit use_b);
    int n;
    n = 0;
    while ((use_b ? qb.size() : qa.size()) != 0 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d beats outstanding, required 0", name,
               use_b ? qb.size() : qa.size());
    end
  endtask

  always @(negedge clock) begin
    if (resetn && bus_a.o_valid) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL beat_a: unexpected beat %0d data %0h, none required", bus_a.o_beat, bus_a.o_data);
      end else if (bus_a.o_data !== qa[0].data || bus_a.o_beat !== qa[0].beat || bus_a.o_last !== qa[0].last) begin
        errors++;
        $display("FAIL beat_a: got beat %0d last %0b data %0h expected beat %0d last %0b data %0h",
                 bus_a.o_beat, bus_a.o_last, bus_a.o_data, qa[0].beat, qa[0].last, qa[0].data);
      end
      if (bus_a.i_ready && qa.size() != 0) begin
        $display("beat A %0d last=%0b data=%0h", bus_a.o_beat, bus_a.o_last, bus_a.o_data);
        void'(qa.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (resetn && bus_b.o_valid) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL beat_b: unexpected beat %0d data %0h, none required", bus_b.o_beat, bus_b.o_data);
      end else if (bus_b.o_data !== qb[0].data[127:0] || {1'b0, bus_b.o_beat} !== qb[0].beat || bus_b.o_last !== qb[0].last) begin
        errors++;
        $display("FAIL beat_b: got beat %0d last %0b data %0h expected beat %0d last %0b data %0h",
                 bus_b.o_beat, bus_b.o_last, bus_b.o_data, qb[0].beat, qb[0].last, qb[0].data);
      end
      if (bus_b.i_ready && qb.size() != 0) begin
        $display("beat B %0d last=%0b data=%0h", bus_b.o_beat, bus_b.o_last, bus_b.o_data);
        void'(qb.pop_front());
      end
    end
  end

  initial begin
    logic [6:0] pattern;
    resetn = 1'b0;
    bus_a.i_results_valid = 1'b0; bus_a.i_results = '0; bus_a.i_ready = 1'b0;
    bus_b.i_results_valid = 1'b0; bus_b.i_results = '0; bus_b.i_ready = 1'b0;
    #12;
    check("reset_valid", 128'(bus_a.o_valid), 128'd0);
    check("reset_beat", 128'(bus_a.o_beat), 128'd0);
    check("reset_last", 128'(bus_a.o_last), 128'd0);
    check("reset_overflow", 128'(bus_a.o_overflow), 128'd0);
    check("reset_data", 128'(bus_a.o_data), 128'd0);
    check("reset_ready", 128'(bus_a.o_results_ready), 128'd1);
    #10 resetn = 1'b1;
    @(posedge clock); #1;

    // Basic drain with i_ready held high.
    bus_a.i_ready = 1'b1;
    strobe_a(32'h1000, 1'b1);
    check("first_beat_latency", 128'(bus_a.o_valid), 128'd1);
    wait_empty("basic", 1'b0);
    check("valid_drop_after_last", 128'(bus_a.o_valid), 128'd0);

    // Backpressure: ready pattern 1,0,0,1,0,1,1 starting with the first valid beat.
    bus_a.i_ready = 1'b0;
    strobe_a(32'h1000, 1'b1);
    pattern = 7'b1101001;
    for (int i = 0; i < 7; i++) begin
      bus_a.i_ready = pattern[i];
      @(posedge clock); #1;
    end
    bus_a.i_ready = 1'b1;
    check("backpressure_all_beats", 128'(qa.size()), 128'd0);
    wait_empty("backpressure", 1'b0);

    // Back-to-back: second strobe lands in the cycle of beat3's handshake.
    strobe_a(32'h1000, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    check("b2b_ready_on_last", 128'(bus_a.o_results_ready), 128'd1);
    strobe_a(32'h2000, 1'b1);
    check("b2b_no_bubble_valid", 128'(bus_a.o_valid), 128'd1);
    check("b2b_restart_beat", 128'(bus_a.o_beat), 128'd0);
    wait_empty("back_to_back", 1'b0);
    check("b2b_no_overflow", 128'(bus_a.o_overflow), 128'd0);

    // Overflow: a strobe while beat1 is stalled is dropped.
    bus_a.i_ready = 1'b0;
    strobe_a(32'h1000, 1'b1);
    bus_a.i_ready = 1'b1;
    @(posedge clock); #1;
    bus_a.i_ready = 1'b0;
    check("stall_ready_low", 128'(bus_a.o_results_ready), 128'd0);
    strobe_a(32'h3000, 1'b0);
    check("overflow_set", 128'(bus_a.o_overflow), 128'd1);
    bus_a.i_ready = 1'b1;
    wait_empty("overflow", 1'b0);
    @(posedge clock); #1;
    check("overflow_sticky", 128'(bus_a.o_overflow), 128'd1);

    // Padding on the 6-result instance: 2 beats, upper lanes of beat1 zero.
    bus_b.i_ready = 1'b1;
    strobe_b(32'h600);
    check("pad_last_on_beat0", 128'(bus_b.o_last), 128'd0);
    wait_empty("padding", 1'b1);
    check("pad_valid_drop", 128'(bus_b.o_valid), 128'd0);

    // Asynchronous reset between edges while beat2 is presented.
    strobe_a(32'h4000, 1'b1);
    repeat (2) @(posedge clock);
    #3;
    qa.delete();
    resetn = 1'b0;
    #1;
    check("async_reset_valid", 128'(bus_a.o_valid), 128'd0);
    @(posedge clock); #3;
    resetn = 1'b1;
    @(posedge clock); #1;
    check("post_reset_ready", 128'(bus_a.o_results_ready), 128'd1);
    check("post_reset_overflow", 128'(bus_a.o_overflow), 128'd0);
    check("post_reset_valid", 128'(bus_a.o_valid), 128'd0);
    strobe_a(32'h5000, 1'b1);
    wait_empty("after_reset", 1'b0);

    repeat (3) @(posedge clock);
    check("final_queue_a", 128'(qa.size()), 128'd0);
    check("final_queue_b", 128'(qb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
Consumer side of the PE accumulator result array. It captures the full parallel result vector in one cycle when the accumulators present a flushed result set. It then serializes the vector onto a narrow valid/ready output stream, LANES results per beat. It sits between the per-PE accumulator bank and the output writeback path, and keeps the accumulators from stalling on a narrow downstream bus.

Parameters:
NUM_RESULTS, 16, number of result words presented per flush (NUM_DOTS*NUM_FEATURES*NUM_FILTERS)
RESULT_WIDTH, 32, bits per result word
LANES, 4, result words per output beat; 1 <= LANES <= NUM_RESULTS
NUM_BEATS, ceil(NUM_RESULTS/LANES), derived localparam; not overridable
BEAT_W, max(1,clog2(NUM_BEATS)), derived width of the beat index

Ports:
clock  in  1  sole clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
i_results_valid  in  1  single-cycle strobe: i_results holds a complete flushed result set
i_results  in  NUM_RESULTS*RESULT_WIDTH  flattened results; word k at bits [k*RESULT_WIDTH +: RESULT_WIDTH]
o_results_ready  out  1  high when a strobe in this cycle will be captured
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts beat when o_valid&&i_ready
o_data  out  LANES*RESULT_WIDTH  beat payload; lane j = word beat*LANES+j
o_beat  out  BEAT_W  index of current beat, 0..NUM_BEATS-1
o_last  out  1  high with o_valid on beat NUM_BEATS-1
o_overflow  out  1  sticky: a strobe arrived while not ready

Behaviour:
- Reset (resetn low, async): state IDLE; o_valid=0, o_beat=0, o_last=0, o_overflow=0, o_data=0, o_results_ready=1. Buffer contents are don't-care; the bench does not check them.
- States: IDLE, DRAIN.
- IDLE: o_results_ready=1, o_valid=0. If i_results_valid, latch all of i_results into the buffer, set beat=0, and go to DRAIN. o_valid rises the next cycle, so strobe-to-first-beat latency is 1 cycle.
- DRAIN: o_valid=1, o_data=buffer words [beat*LANES .. beat*LANES+LANES-1], o_last=(beat==NUM_BEATS-1).
- DRAIN beat advance: on handshake with beat<NUM_BEATS-1, beat increments. With no handshake, o_data, o_beat and o_last hold stable; a valid beat never retracts.
- DRAIN final handshake (beat==NUM_BEATS-1 && i_ready): if i_results_valid in the same cycle, capture the new set, reset beat=0, and stay in DRAIN. This allows back-to-back sets with no bubble. Otherwise go to IDLE.
- o_results_ready is combinational: 1 in IDLE, or in DRAIN when beat==NUM_BEATS-1 && i_ready. It is 0 otherwise.
- Strobe while o_results_ready=0: the set is dropped (buffer and beat untouched) and o_overflow is set. o_overflow clears only on reset.
- Partial last beat (NUM_RESULTS not a multiple of LANES): lanes past NUM_RESULTS-1 drive 0.
- NUM_BEATS==1: every beat is also the last beat; o_last=1 whenever o_valid=1.
- Reset mid-drain: immediate return to IDLE; undrained beats are lost; no spurious o_valid after release.
- No combinational path from i_results to o_data; o_data comes from the buffer register only.

Test Plan:
- Basic drain, defaults: strobe with word k = 0x1000+k, i_ready held 1 -> 4 consecutive beats starting next cycle; beat0 lanes=0x1000..0x1003, beat3=0x100C..0x100F; o_last only on beat3; o_valid drops the following cycle.
- Backpressure: same stimulus, i_ready toggling 1,0,0,1,0,1,1 -> each beat's o_data/o_beat held while i_ready=0; exactly 4 handshakes in order; no duplicates or skips.
- Back-to-back: second strobe (words 0x2000+k) in the cycle of beat3's handshake -> o_results_ready=1 that cycle; beat0 of the new set (0x2000..0x2003) presented the next cycle, no idle bubble; o_overflow stays 0.
- Overflow: strobe while beat1 is stalled -> o_overflow=1 and stays 1; drain finishes with the original 0x1000-series data.
- Padding, NUM_RESULTS=6, LANES=4 -> 2 beats; beat1 lanes0-1 = words 4,5; lanes2-3 = 0; o_beat width 1.
- Async reset mid-drain: assert resetn=0 between clock edges during beat2 -> o_valid=0 immediately; after release o_results_ready=1, o_overflow=0; a new strobe drains normally from beat0.
